// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: 8 x WIDTH register file plus a one-deep valid/ready output register.
// Define OPERAND_BYPASS_EN to forward a same-cycle writeback into the captured operands.
module alu_operand_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_ra,
  input  logic [2:0]       in_rb,
  input  logic [2:0]       in_rd,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       out_op,
  output logic [2:0]       out_rd
);

  logic [WIDTH-1:0] rf_q [8];
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       rd_q, rd_d;
  logic             accept;
  logic             wb_hit;
  logic [WIDTH-1:0] ra_val, rb_val;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_addr != 3'd0);

  // R0 is hard-wired to zero on the read side as well as never written.
  always_comb begin
    ra_val = (in_ra == 3'd0) ? '0 : rf_q[in_ra];
    rb_val = (in_rb == 3'd0) ? '0 : rf_q[in_rb];
`ifdef OPERAND_BYPASS_EN
    if (wb_hit && (wb_addr == in_ra)) ra_val = wb_data;
    if (wb_hit && (wb_addr == in_rb)) rb_val = wb_data;
`endif
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = ra_val;
      b_d     = in_use_imm ? in_imm : rb_val;
      op_d    = in_op;
      rd_d    = in_rd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      if (wb_hit) rf_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_op    = op_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed table-driven bench for alu_operand_stage (WIDTH=16).
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_ra, in_rb, in_rd;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [2:0]  out_rd;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef OPERAND_BYPASS_EN
  localparam logic [15:0] R2_SAME_CYCLE = 16'hBEEF;
`else
  localparam logic [15:0] R2_SAME_CYCLE = 16'h0011;
`endif

  alu_operand_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wbe;
    logic [2:0]  wba;
    logic [15:0] wbd;
    logic        iv;
    logic [2:0]  ra, rb, rd;
    logic [3:0]  op;
    logic        ui;
    logic [15:0] imm;
    logic        ordy;
    logic        e_rdy;
    logic        e_v;
    logic [15:0] e_a, e_b;
    logic [3:0]  e_op;
    logic [2:0]  e_rd;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic wbe, logic [2:0] wba, logic [15:0] wbd,
                              logic iv, logic [2:0] ra, logic [2:0] rb, logic [2:0] rd,
                              logic [3:0] op, logic ui, logic [15:0] imm, logic ordy,
                              logic e_rdy, logic e_v, logic [15:0] e_a, logic [15:0] e_b,
                              logic [3:0] e_op, logic [2:0] e_rd);
    vec_t v;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.iv = iv; v.ra = ra; v.rb = rb; v.rd = rd;
    v.op = op; v.ui = ui; v.imm = imm; v.ordy = ordy; v.e_rdy = e_rdy; v.e_v = e_v;
    v.e_a = e_a; v.e_b = e_b; v.e_op = e_op; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(int idx, logic v, logic [15:0] a, logic [15:0] b,
                            logic [3:0] op, logic [2:0] rd);
    chk("out_valid", idx, {31'd0, out_valid}, {31'd0, v});
    chk("out_a",     idx, {16'd0, out_a},     {16'd0, a});
    chk("out_b",     idx, {16'd0, out_b},     {16'd0, b});
    chk("out_op",    idx, {28'd0, out_op},    {28'd0, op});
    chk("out_rd",    idx, {29'd0, out_rd},    {29'd0, rd});
  endtask

  // Drive just after a rising edge, check in_ready mid-cycle, check outputs after the next edge.
  task automatic step(int idx, vec_t v);
    wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
    in_valid = v.iv; in_ra = v.ra; in_rb = v.rb; in_rd = v.rd; in_op = v.op;
    in_use_imm = v.ui; in_imm = v.imm; out_ready = v.ordy;
    #2;
    chk("in_ready", idx, {31'd0, in_ready}, {31'd0, v.e_rdy});
    @(posedge clk); #1;
    check_outs(idx, v.e_v, v.e_a, v.e_b, v.e_op, v.e_rd);
  endtask

  initial begin
    //            wbe wba  wbd       iv ra rb rd op    ui imm       ordy rdy v  a          b          op    rd
    tbl[0]  = mk(1, 3'd3, 16'h1234, 0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   1,  0, 16'h0000, 16'h0000, 4'h0, 3'd0);
    tbl[1]  = mk(1, 3'd5, 16'h0001, 1, 3, 0, 1, 4'h2, 0, 16'h0000, 1,   1,  1, 16'h1234, 16'h0000, 4'h2, 3'd1);
    tbl[2]  = mk(0, 3'd0, 16'h0000, 1, 0, 5, 2, 4'h3, 1, 16'hFFFF, 1,   1,  1, 16'h0000, 16'hFFFF, 4'h3, 3'd2);
    tbl[3]  = mk(0, 3'd0, 16'h0000, 1, 5, 3, 7, 4'hF, 0, 16'h0000, 1,   1,  1, 16'h0001, 16'h1234, 4'hF, 3'd7);
    tbl[4]  = mk(1, 3'd0, 16'h5555, 0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   1,  0, 16'h0001, 16'h1234, 4'hF, 3'd7);
    tbl[5]  = mk(0, 3'd0, 16'h0000, 1, 0, 0, 0, 4'h1, 0, 16'h0000, 1,   1,  1, 16'h0000, 16'h0000, 4'h1, 3'd0);
    tbl[6]  = mk(1, 3'd2, 16'h0011, 0, 0, 0, 0, 4'h0, 0, 16'h0000, 1,   1,  0, 16'h0000, 16'h0000, 4'h1, 3'd0);
    tbl[7]  = mk(1, 3'd2, 16'hBEEF, 1, 2, 2, 4, 4'h6, 0, 16'h0000, 1,   1,  1, R2_SAME_CYCLE, R2_SAME_CYCLE, 4'h6, 3'd4);
    tbl[8]  = mk(0, 3'd0, 16'h0000, 1, 2, 3, 5, 4'h7, 0, 16'h0000, 1,   1,  1, 16'hBEEF, 16'h1234, 4'h7, 3'd5);
    // Three stalled cycles with R3 being rewritten underneath the held bundle.
    tbl[9]  = mk(1, 3'd3, 16'hAAAA, 1, 3, 1, 6, 4'h8, 0, 16'h0000, 0,   0,  1, 16'hBEEF, 16'h1234, 4'h7, 3'd5);
    tbl[10] = mk(1, 3'd3, 16'hBBBB, 1, 3, 1, 6, 4'h8, 0, 16'h0000, 0,   0,  1, 16'hBEEF, 16'h1234, 4'h7, 3'd5);
    tbl[11] = mk(1, 3'd3, 16'hCCCC, 1, 3, 1, 6, 4'h8, 0, 16'h0000, 0,   0,  1, 16'hBEEF, 16'h1234, 4'h7, 3'd5);
    tbl[12] = mk(0, 3'd0, 16'h0000, 1, 3, 1, 6, 4'h8, 0, 16'h0000, 1,   1,  1, 16'hCCCC, 16'h0000, 4'h8, 3'd6);
    tbl[13] = mk(0, 3'd0, 16'h0000, 1, 3, 4, 3, 4'h9, 0, 16'h0000, 1,   1,  1, 16'hCCCC, 16'h0000, 4'h9, 3'd3);

    rst = 1'b1; in_valid = 0; in_ra = 0; in_rb = 0; in_rd = 0; in_op = 0;
    in_use_imm = 0; in_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outs(-1, 0, 16'h0, 16'h0, 4'h0, 3'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", -1, {31'd0, in_ready}, 32'd1);
    #1;

    for (int i = 0; i < 14; i++) step(i, tbl[i]);

    // Reset while a bundle is pending, colliding with an accept and a write to R4.
    out_ready = 0; in_valid = 1; in_ra = 3; in_rb = 2; in_op = 4'hA; in_rd = 3'd1;
    wb_en = 1; wb_addr = 3'd4; wb_data = 16'h1111; rst = 1;
    @(posedge clk); #1;
    rst = 0; wb_en = 0; in_valid = 0;
    check_outs(100, 0, 16'h0, 16'h0, 4'h0, 3'd0);
    chk("in_ready_rst", 100, {31'd0, in_ready}, 32'd1);
    #1;
    // Registers must be cleared and the overridden R4 write must not have landed.
    in_valid = 1; in_ra = 3; in_rb = 4; in_use_imm = 0; in_op = 4'h5; in_rd = 3'd2; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check_outs(101, 1, 16'h0000, 16'h0000, 4'h5, 3'd2);
    @(posedge clk); #1;
    chk("drain_valid", 102, {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
